// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-schedule and keystream blocks.
package rc4_pkg;

  localparam int S_DEPTH       = 256;
  localparam int BYTE_W        = 8;
  localparam int MAX_KEY_BYTES = 32;
  localparam int MAX_RD_LAT    = 4;
  localparam int WAIT_W        = $clog2(MAX_RD_LAT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD_I,
    ST_CALC_J,
    ST_RD_J,
    ST_WR_I,
    ST_WR_J,
    ST_DONE
  } ksa_state_e;

endpackage

// File: rtl/rc4_key_byte_sel.sv
// Picks key byte k out of a packed key bus; byte 0 sits in the most significant byte.
module rc4_key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int K_W       = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic [BYTE_W*KEY_BYTES-1:0] key,
  input  logic [K_W-1:0]              k,
  output logic [BYTE_W-1:0]           key_byte
);

  logic [KEY_BYTES-1:0][BYTE_W-1:0] bytes;

  for (genvar b = 0; b < KEY_BYTES; b++) begin : g_byte
    assign bytes[b] = key[BYTE_W*(KEY_BYTES-1-b) +: BYTE_W];
  end

  // Compare-based mux so non-power-of-two key lengths never index past the array.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k == K_W'(b)) key_byte = bytes[b];
    end
  end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: optional identity fill, then 256 read-read-swap iterations
// over a single-port S-box RAM with configurable read latency.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1,
  parameter int INIT_EN   = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [BYTE_W*KEY_BYTES-1:0] secret_key,
  input  logic [BYTE_W-1:0]           mem_rdata,
  output logic [BYTE_W-1:0]           mem_addr,
  output logic [BYTE_W-1:0]           mem_wdata,
  output logic                        mem_wren,
  output logic                        busy,
  output logic                        done
);

  localparam int                KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]     K_LAST    = KW'(KEY_BYTES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
  localparam logic [BYTE_W-1:0] I_LAST    = BYTE_W'(S_DEPTH - 1);

  ksa_state_e                  state_q, state_d;
  logic [BYTE_W-1:0]           i_q, i_d;
  logic [BYTE_W-1:0]           j_q, j_d;
  logic [KW-1:0]               k_q, k_d;
  logic [BYTE_W-1:0]           si_q, si_d;
  logic [BYTE_W-1:0]           sj_q, sj_d;
  logic [WAIT_W-1:0]           wait_q, wait_d;
  logic [BYTE_W*KEY_BYTES-1:0] key_q, key_d;
  logic [BYTE_W-1:0]           addr_q, addr_d;
  logic [BYTE_W-1:0]           wdata_q, wdata_d;
  logic                        wren_q, wren_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [BYTE_W-1:0]           key_byte;

  rc4_key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .K_W       (KW)
  ) u_key_sel (
    .key      (key_q),
    .k        (k_q),
    .key_byte (key_byte)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    si_d    = si_q;
    sj_d    = sj_q;
    wait_d  = wait_q;
    key_d   = key_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = secret_key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          wait_d  = '0;
          state_d = (INIT_EN != 0) ? ST_INIT : ST_RD_I;
        end
      end
      ST_INIT: begin
        i_d    = i_q + 8'd1;
        wait_d = '0;
        if (i_q == I_LAST) state_d = ST_RD_I;
      end
      ST_RD_I: begin
        if (wait_q == WAIT_LAST) begin
          si_d    = mem_rdata;
          state_d = ST_CALC_J;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_CALC_J: begin
        j_d     = j_q + si_q + key_byte;
        wait_d  = '0;
        state_d = ST_RD_J;
      end
      ST_RD_J: begin
        if (wait_q == WAIT_LAST) begin
          sj_d    = mem_rdata;
          state_d = ST_WR_I;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WR_I: state_d = ST_WR_J;
      ST_WR_J: begin
        i_d     = i_q + 8'd1;
        k_d     = (k_q == K_LAST) ? '0 : k_q + KW'(1);
        wait_d  = '0;
        state_d = (i_q == I_LAST) ? ST_DONE : ST_RD_I;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Port values are derived from the next state so the RAM sees them the
    // same cycle the state is entered, with no extra output lag.
    addr_d  = '0;
    wdata_d = '0;
    wren_d  = 1'b0;
    case (state_d)
      ST_INIT: begin
        addr_d  = i_d;
        wdata_d = i_d;
        wren_d  = 1'b1;
      end
      ST_RD_I: addr_d = i_d;
      ST_RD_J: addr_d = j_d;
      ST_WR_I: begin
        addr_d  = i_d;
        wdata_d = sj_d;
        wren_d  = 1'b1;
      end
      ST_WR_J: begin
        addr_d  = j_d;
        wdata_d = si_d;
        wren_d  = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      wait_q  <= '0;
      key_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      wait_q  <= wait_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wren  = wren_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench: four engine configurations, each with its own behavioural S-RAM, checked
// against a plain-arithmetic RC4 key schedule.
`timescale 1ns/1ps
module tb_rc4_ksa_engine;

  localparam int NI = 4;
  localparam int KB_T  [NI] = '{3, 3, 16, 1};
  localparam int LAT_T [NI] = '{1, 2, 4, 1};
  localparam int IEN_T [NI] = '{1, 0, 1, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0]        start, wren, busy, done, ld;
  logic [NI-1:0][127:0] key_bus;
  logic [NI-1:0][7:0]   addr, wdata, rdata, dbg_data;
  logic [7:0]           dbg_addr;
  logic [7:0]           gold [256];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [7:0] mem  [256];
    logic [7:0] pipe [3];

    rc4_ksa_engine #(
      .KEY_BYTES (KB_T[g]),
      .RD_LAT    (LAT_T[g]),
      .INIT_EN   (IEN_T[g])
    ) u_dut (
      .CLOCK_50   (clk),
      .reset_n    (rst_n),
      .start      (start[g]),
      .secret_key (key_bus[g][8*KB_T[g]-1:0]),
      .mem_rdata  (rdata[g]),
      .mem_addr   (addr[g]),
      .mem_wdata  (wdata[g]),
      .mem_wren   (wren[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );

    always @(posedge clk) begin
      if (ld[g]) begin
        for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
      end else if (wren[g]) begin
        mem[addr[g]] <= wdata[g];
      end
      pipe[0] <= mem[addr[g]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    if (LAT_T[g] == 1) begin : g_comb
      assign rdata[g] = mem[addr[g]];
    end else begin : g_reg
      assign rdata[g] = pipe[LAT_T[g]-2];
    end
    assign dbg_data[g] = mem[dbg_addr];
  end

  task automatic golden(input logic [127:0] key, input int kb);
    int j;
    logic [7:0] t, kbyte;
    j = 0;
    for (int i = 0; i < 256; i++) gold[i] = 8'(i);
    for (int i = 0; i < 256; i++) begin
      kbyte = key[8*(kb-1-(i % kb)) +: 8];
      j = (j + int'(gold[i]) + int'(kbyte)) % 256;
      t = gold[i]; gold[i] = gold[j]; gold[j] = t;
    end
  endtask

  // mode: 0 plain, 1 first-iteration probes, 3 i==j writes, 5 start/key disturbance, 6 abort
  task automatic run_ksa(input int g, input logic [127:0] key, input int mode, input string nm);
    int exp_done, cnt, first_done, n_done, busy_gap, wd_bad, zero_wr, bad, first_bad;
    logic [7:0] s0, s1;
    exp_done = 256*IEN_T[g] + 256*(2*LAT_T[g] + 3) + 1;
    first_done = -1; n_done = 0; busy_gap = 0; wd_bad = 0; zero_wr = 0;
    golden(key, KB_T[g]);
    @(negedge clk);
    key_bus[g] = key;
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    cnt = 1;
    n_checks++;
    if (busy[g] !== 1'b1) $display("FAIL %s.busy_after_accept got %b want 1", nm, busy[g]);
    else n_pass++;
    while (cnt <= exp_done + 4) begin
      if (done[g] === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = cnt;
      end
      if (cnt < exp_done && busy[g] !== 1'b1) busy_gap++;
      if (wren[g] !== 1'b1 && wdata[g] !== 8'h00) wd_bad++;
      if (mode == 1 && cnt == 259) begin
        n_checks++;
        if (addr[g] !== 8'h01 || wren[g] !== 1'b0)
          $display("FAIL %s.rd_j_addr got %h/%b want 01/0", nm, addr[g], wren[g]);
        else n_pass++;
      end
      if (mode == 1 && cnt == 262) begin
        dbg_addr = 8'd0; #1 s0 = dbg_data[g];
        dbg_addr = 8'd1; #1 s1 = dbg_data[g];
        n_checks++;
        if ({s0, s1} !== 16'h0100) $display("FAIL %s.iter0_swap got %h want 0100", nm, {s0, s1});
        else n_pass++;
      end
      if (mode == 3 && (cnt == 260 || cnt == 261) && wren[g] === 1'b1 &&
          addr[g] === 8'h00 && wdata[g] === 8'h00) zero_wr++;
      if (mode == 5) begin
        start[g] = (cnt == 10 || cnt == 259);
        if (cnt == 600) key_bus[g] = ~key;
      end
      if (mode == 6 && cnt == 758) begin
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wren[g], busy[g], done[g]} !== 3'b000)
          $display("FAIL %s.abort_outputs got %b want 000", nm, {wren[g], busy[g], done[g]});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      cnt++;
    end
    start[g] = 1'b0;
    n_checks++;
    if (first_done != exp_done) $display("FAIL %s.done_cycle got %0d want %0d", nm, first_done, exp_done);
    else n_pass++;
    n_checks++;
    if (n_done != 1) $display("FAIL %s.done_pulses got %0d want 1", nm, n_done);
    else n_pass++;
    n_checks++;
    if (busy_gap != 0 || busy[g] !== 1'b0)
      $display("FAIL %s.busy_window got gaps=%0d end=%b want 0/0", nm, busy_gap, busy[g]);
    else n_pass++;
    n_checks++;
    if (wd_bad != 0) $display("FAIL %s.wdata_idle got %0d nonzero want 0", nm, wd_bad);
    else n_pass++;
    if (mode == 3) begin
      n_checks++;
      if (zero_wr != 2) $display("FAIL %s.i_eq_j_writes got %0d want 2", nm, zero_wr);
      else n_pass++;
    end
    bad = 0; first_bad = -1;
    for (int a = 0; a < 256; a++) begin
      dbg_addr = 8'(a);
      #1;
      if (dbg_data[g] !== gold[a]) begin
        bad++;
        if (first_bad < 0) first_bad = a;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL %s.sbox got %0d wrong bytes (first at %0d) want 0", nm, bad, first_bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = '0; ld = '0; key_bus = '0; dbg_addr = '0;
    #12;
    for (int g = 0; g < NI; g++) begin
      n_checks++;
      if ({addr[g], wdata[g], wren[g], busy[g], done[g]} !== 19'd0)
        $display("FAIL reset.outputs[%0d] got %h want 0", g, {addr[g], wdata[g], wren[g], busy[g], done[g]});
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_ksa(0, 128'h010203, 1, "basic");
  endtask

  task automatic test_no_init();
    @(negedge clk); ld[1] = 1'b1;
    @(negedge clk); ld[1] = 1'b0;
    run_ksa(1, 128'h000249, 0, "no_init");
  endtask

  task automatic test_i_eq_j();
    run_ksa(3, 128'h00, 3, "i_eq_j");
  endtask

  task automatic test_long_key();
    run_ksa(2, {$urandom, $urandom, $urandom, $urandom}, 0, "long_key");
  endtask

  task automatic test_ignore_start();
    run_ksa(0, 128'($urandom_range(0, 32'hFFFFFF)), 5, "ignore");
  endtask

  task automatic test_abort();
    run_ksa(0, 128'($urandom_range(0, 32'hFFFFFF)), 6, "abort");
    run_ksa(0, 128'($urandom_range(0, 32'hFFFFFF)), 0, "rerun");
  endtask

  task automatic test_back_to_back();
    run_ksa(3, 128'($urandom_range(0, 255)), 0, "b2b_a");
    run_ksa(3, 128'($urandom_range(0, 255)), 0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_init();
    test_i_eq_j();
    test_long_key();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
